// File: rtl/pe_feeder.sv
// Packet loader for a single PE: forwards instruction words, buffers complex data,
// then replays the data as one contiguous burst after a fixed idle gap.
module pe_feeder #(
    parameter int DATA_WIDTH    = 16,
    parameter int INST_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int INST_DATA_GAP = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_v,
    input  logic [31:0]             s_data,
    output logic                    s_rdy,
    output logic                    inst_in_v,
    output logic [INST_WIDTH-1:0]   inst_in,
    output logic                    din_pe_v,
    output logic [2*DATA_WIDTH-1:0] din_pe,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int DW = 2 * DATA_WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 16;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] GAP_LAST = CW'(INST_DATA_GAP - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INST    = 3'd1;
    localparam logic [2:0] ST_COLLECT = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_BURST   = 3'd4;
    localparam logic [2:0] ST_DROP    = 3'd5;

    logic [2:0]          state_r;
    logic [2:0]          state_nxt;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nxt;
    logic [7:0]          n_inst_r;
    logic [7:0]          n_data_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [DW-1:0]       mem_r [DEPTH];

    logic                s_rdy_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                inst_v_r;
    logic [INST_WIDTH-1:0] inst_r;
    logic                din_v_r;
    logic [DW-1:0]       din_r;

    logic                accept_s;
    logic [7:0]          hdr_inst_s;
    logic [7:0]          hdr_data_s;
    logic [CW-1:0]       drop_total_s;
    logic                done_nxt;
    logic                err_nxt;
    logic                inst_v_nxt;
    logic                din_v_nxt;
    logic                fifo_we_s;
    logic                fifo_re_s;
    logic                s_rdy_nxt;
    logic                busy_nxt;

    assign accept_s     = s_v & s_rdy_r;
    assign hdr_inst_s   = s_data[15:8];
    assign hdr_data_s   = s_data[7:0];
    assign drop_total_s = CW'(n_inst_r) + CW'(n_data_r);

    assign s_rdy     = s_rdy_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign inst_in_v = inst_v_r;
    assign inst_in   = inst_r;
    assign din_pe_v  = din_v_r;
    assign din_pe    = din_r;

    // Next-state, counter and output-strobe decode for the packet sequencer
    always_comb begin
        state_nxt  = state_r;
        cnt_nxt    = cnt_r;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        inst_v_nxt = 1'b0;
        din_v_nxt  = 1'b0;
        fifo_we_s  = 1'b0;
        fifo_re_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_nxt = {CW{1'b0}};
                    if (CW'(hdr_data_s) > DEPTH_C) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DROP;
                    end else if (hdr_inst_s != 8'd0) begin
                        state_nxt = ST_INST;
                    end else if (hdr_data_s != 8'd0) begin
                        state_nxt = ST_COLLECT;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_INST: begin
                if (accept_s) begin
                    inst_v_nxt = 1'b1;
                    if (cnt_r == CW'(n_inst_r) - 16'd1) begin
                        cnt_nxt = {CW{1'b0}};
                        if (n_data_r != 8'd0) begin
                            state_nxt = ST_COLLECT;
                        end else begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt_r + 16'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r;
                end
            end
            ST_COLLECT: begin
                if (accept_s) begin
                    fifo_we_s = 1'b1;
                    if (cnt_r == CW'(n_data_r) - 16'd1) begin
                        cnt_nxt   = {CW{1'b0}};
                        // a zero gap skips the wait state entirely
                        if (INST_DATA_GAP == 0) begin
                            state_nxt = ST_BURST;
                        end else begin
                            state_nxt = ST_GAP;
                        end
                    end else begin
                        cnt_nxt = cnt_r + 16'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nxt   = {CW{1'b0}};
                    state_nxt = ST_BURST;
                end else begin
                    cnt_nxt = cnt_r + 16'd1;
                end
            end
            ST_BURST: begin
                // one extra cycle after the last read raises done and frees the host port
                if (cnt_r < CW'(n_data_r)) begin
                    fifo_re_s = 1'b1;
                    din_v_nxt = 1'b1;
                    cnt_nxt   = cnt_r + 16'd1;
                end else begin
                    done_nxt  = 1'b1;
                    cnt_nxt   = {CW{1'b0}};
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept_s) begin
                    if (cnt_r == drop_total_s - 16'd1) begin
                        cnt_nxt   = {CW{1'b0}};
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt_r + 16'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r;
                end
            end
            default: begin
                cnt_nxt   = {CW{1'b0}};
                state_nxt = ST_IDLE;
            end
        endcase
        s_rdy_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_INST) ||
                    (state_nxt == ST_COLLECT) || (state_nxt == ST_DROP);
        busy_nxt  = (state_nxt != ST_IDLE);
    end

    // Sequencer state, counters, FIFO pointers and registered PE-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            n_inst_r <= 8'd0;
            n_data_r <= 8'd0;
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            s_rdy_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            inst_v_r <= 1'b0;
            inst_r   <= {INST_WIDTH{1'b0}};
            din_v_r  <= 1'b0;
            din_r    <= {DW{1'b0}};
        end else begin
            state_r  <= state_nxt;
            cnt_r    <= cnt_nxt;
            s_rdy_r  <= s_rdy_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
            err_r    <= err_nxt;
            inst_v_r <= inst_v_nxt;
            din_v_r  <= din_v_nxt;
            if ((state_r == ST_IDLE) && accept_s) begin
                n_inst_r <= hdr_inst_s;
                n_data_r <= hdr_data_s;
            end
            if (inst_v_nxt) begin
                inst_r <= s_data[INST_WIDTH-1:0];
            end
            if (fifo_we_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (fifo_re_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
                din_r    <= mem_r[rd_ptr_r];
            end
        end
    end

    // Data buffer storage; stale contents are harmless once pointers clear
    always_ff @(posedge clk) begin
        if (fifo_we_s) begin
            mem_r[wr_ptr_r] <= s_data[DW-1:0];
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: packet-level reference model checked every cycle,
// plus literal expectations per scenario.
module tb_pe_feeder;

    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_v = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        s_rdy;
    logic        inst_in_v;
    logic [31:0] inst_in;
    logic        din_pe_v;
    logic [31:0] din_pe;
    logic        busy;
    logic        done;
    logic        err;

    pe_feeder #(.DATA_WIDTH(16), .INST_WIDTH(32), .DEPTH(16), .INST_DATA_GAP(G)) dut (
        .clk(clk), .rst(rst), .s_v(s_v), .s_data(s_data), .s_rdy(s_rdy),
        .inst_in_v(inst_in_v), .inst_in(inst_in), .din_pe_v(din_pe_v), .din_pe(din_pe),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // packet-level model: expected events keyed by cycle number
    int mode = 0;
    int rem = 0;
    int nd_m = 0;
    int ni_h, nd_h;
    logic [31:0] dq[$];
    int win_lo = -1;
    int win_hi = -1;
    bit in_win;
    logic [31:0] exp_inst[int];
    logic [31:0] exp_din[int];
    bit exp_done[int];
    bit exp_err[int];

    logic [31:0] obs_inst[$];
    logic [31:0] obs_din[$];
    int obs_done, obs_err, n_acc, acc_cyc, done_cyc;
    int first_din, last_din, first_inst, last_inst;
    logic [31:0] pw[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        in_win = (cyc >= win_lo) && (cyc <= win_hi);
        chk("s_rdy", 32'(s_rdy), 32'(!in_win));
        chk("busy", 32'(busy), 32'((mode != 0) || in_win));
        chk("inst_in_v", 32'(inst_in_v), 32'(exp_inst.exists(cyc)));
        if (inst_in_v && exp_inst.exists(cyc)) chk("inst_in", inst_in, exp_inst[cyc]);
        chk("din_pe_v", 32'(din_pe_v), 32'(exp_din.exists(cyc)));
        if (din_pe_v && exp_din.exists(cyc)) chk("din_pe", din_pe, exp_din[cyc]);
        chk("done", 32'(done), 32'(exp_done.exists(cyc)));
        chk("err", 32'(err), 32'(exp_err.exists(cyc)));

        if (inst_in_v) begin
            obs_inst.push_back(inst_in);
            if (first_inst < 0) first_inst = cyc;
            last_inst = cyc;
        end
        if (din_pe_v) begin
            obs_din.push_back(din_pe);
            if (first_din < 0) first_din = cyc;
            last_din = cyc;
        end
        if (done) begin obs_done++; done_cyc = cyc; end
        if (err) obs_err++;

        if (rst) begin
            mode = 0; rem = 0; win_lo = -1; win_hi = -1;
            exp_inst.delete(); exp_din.delete(); exp_done.delete(); exp_err.delete();
        end else if (s_v && !in_win) begin
            n_acc++;
            acc_cyc = cyc + 1;
            case (mode)
                0: begin
                    ni_h = int'(s_data[15:8]);
                    nd_h = int'(s_data[7:0]);
                    if (nd_h > 16) begin
                        exp_err[cyc+1] = 1'b1; rem = ni_h + nd_h; mode = 3;
                    end else if (ni_h > 0) begin
                        rem = ni_h; nd_m = nd_h; mode = 1;
                    end else if (nd_h > 0) begin
                        rem = nd_h; nd_m = nd_h; mode = 2; dq.delete();
                    end else begin
                        exp_done[cyc+1] = 1'b1;
                    end
                end
                1: begin
                    exp_inst[cyc+1] = s_data;
                    rem--;
                    if (rem == 0) begin
                        if (nd_m > 0) begin mode = 2; rem = nd_m; dq.delete(); end
                        else begin exp_done[cyc+1] = 1'b1; mode = 0; end
                    end
                end
                2: begin
                    dq.push_back(s_data);
                    rem--;
                    if (rem == 0) begin
                        for (int i = 0; i < nd_m; i++) exp_din[cyc+G+2+i] = dq[i];
                        exp_done[cyc+G+2+nd_m] = 1'b1;
                        win_lo = cyc + 1;
                        win_hi = cyc + G + 1 + nd_m;
                        mode = 0;
                    end
                end
                default: begin
                    rem--;
                    if (rem == 0) mode = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_inst.delete(); obs_din.delete();
        obs_done = 0; obs_err = 0; n_acc = 0; acc_cyc = -1; done_cyc = -1;
        first_din = -1; last_din = -1; first_inst = -1; last_inst = -1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit bub);
        bit ok;
        ok = 1'b0;
        if (bub) begin s_v = 1'b0; tick(); end
        s_v = 1'b1;
        s_data = w;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = s_rdy;
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout word=%h actual=not_accepted expected=accepted", w);
        end
    endtask

    task automatic send_pkt(input bit bub);
        foreach (pw[i]) send_word(pw[i], bub);
        s_v = 1'b0;
    endtask

    task automatic load_nominal();
        pw = '{32'h0000_0306, 32'h8001_0080, 32'h8003_0281, 32'h8005_0482,
               32'h0004_0002, 32'h0003_0001, 32'h0008_0006, 32'h0007_0005,
               32'h000C_000A, 32'h000B_0009};
    endtask

    task automatic check_nominal(input string tag);
        chk({tag, "_inst_cnt"}, obs_inst.size(), 32'd3);
        if (obs_inst.size() == 3) begin
            chk({tag, "_inst0"}, obs_inst[0], 32'h8001_0080);
            chk({tag, "_inst1"}, obs_inst[1], 32'h8003_0281);
            chk({tag, "_inst2"}, obs_inst[2], 32'h8005_0482);
        end
        chk({tag, "_din_cnt"}, obs_din.size(), 32'd6);
        if (obs_din.size() == 6) begin
            chk({tag, "_din0"}, obs_din[0], 32'h0004_0002);
            chk({tag, "_din3"}, obs_din[3], 32'h0007_0005);
            chk({tag, "_din5"}, obs_din[5], 32'h000B_0009);
        end
        chk({tag, "_din_contig"}, last_din - first_din, 32'd5);
        chk({tag, "_done_cnt"}, obs_done, 32'd1);
    endtask

    initial begin
        clear_obs();
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_s_rdy", 32'(s_rdy), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);

        // nominal packet, back-to-back words
        clear_obs(); load_nominal(); send_pkt(1'b0);
        repeat (20) tick();
        check_nominal("nominal");
        chk("nominal_inst_contig", last_inst - first_inst, 32'd2);
        chk("nominal_burst_start", first_din - acc_cyc, 32'd3);

        // same packet with a bubble before every word
        clear_obs(); load_nominal(); send_pkt(1'b1);
        repeat (20) tick();
        check_nominal("bubble");
        chk("bubble_inst_gaps", last_inst - first_inst, 32'd4);

        // empty packet
        clear_obs(); pw = '{32'h0000_0000}; send_pkt(1'b0);
        repeat (5) tick();
        chk("empty_done", obs_done, 32'd1);
        chk("empty_done_cyc", done_cyc, acc_cyc);
        chk("empty_valids", obs_inst.size() + obs_din.size(), 32'd0);

        // instructions only
        clear_obs(); pw = '{32'h0000_0200, 32'hB101_0000, 32'hD203_0200}; send_pkt(1'b0);
        repeat (5) tick();
        chk("instonly_cnt", obs_inst.size(), 32'd2);
        if (obs_inst.size() == 2) chk("instonly_1", obs_inst[1], 32'hD203_0200);
        chk("instonly_din", obs_din.size(), 32'd0);
        chk("instonly_done", obs_done, 32'd1);

        // FIFO exactly full
        clear_obs(); pw = '{32'h0000_0010};
        for (int i = 0; i < 16; i++) pw.push_back(32'h1000_0000 + 32'(i));
        send_pkt(1'b0);
        repeat (30) tick();
        chk("full_cnt", obs_din.size(), 32'd16);
        for (int i = 0; i < obs_din.size(); i++) chk("full_order", obs_din[i], 32'h1000_0000 + 32'(i));
        chk("full_done", obs_done, 32'd1);

        // two 10-word packets; the second crosses the pointer wrap
        for (int p = 0; p < 2; p++) begin
            clear_obs(); pw = '{32'h0000_000A};
            for (int i = 0; i < 10; i++) pw.push_back(32'h2000_0000 + 32'(p << 16) + 32'(i));
            send_pkt(1'b0);
            repeat (20) tick();
            chk("wrap_cnt", obs_din.size(), 32'd10);
            for (int i = 0; i < obs_din.size(); i++)
                chk("wrap_order", obs_din[i], 32'h2000_0000 + 32'(p << 16) + 32'(i));
        end

        // oversized header is consumed and discarded
        clear_obs(); pw = '{32'h0000_0111};
        for (int i = 0; i < 18; i++) pw.push_back(32'hDEAD_0000 + 32'(i));
        send_pkt(1'b0);
        repeat (5) tick();
        chk("over_err", obs_err, 32'd1);
        chk("over_consumed", n_acc, 32'd19);
        chk("over_valids", obs_inst.size() + obs_din.size() + obs_done, 32'd0);
        clear_obs(); load_nominal(); send_pkt(1'b0);
        repeat (20) tick();
        check_nominal("after_over");

        // reset during the third burst cycle
        begin
            int seen;
            seen = 0;
            clear_obs(); load_nominal(); send_pkt(1'b0);
            for (int t = 0; t < 50 && seen < 3; t++) begin
                tick();
                if (din_pe_v) seen++;
            end
            chk("rst_reached_beat3", seen, 32'd3);
            rst = 1'b1;
            tick();
            chk("rst_din_v", 32'(din_pe_v), 32'd0);
            chk("rst_inst_v", 32'(inst_in_v), 32'd0);
            chk("rst_s_rdy", 32'(s_rdy), 32'd1);
            rst = 1'b0;
            repeat (10) tick();
            chk("rst_no_done", obs_done, 32'd0);
        end
        clear_obs(); load_nominal(); send_pkt(1'b0);
        repeat (20) tick();
        check_nominal("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
Name: pe_feeder

Overview:
- Upstream loader for a single PE. Accepts a packetised 32-bit host stream (valid/ready).
- Forwards the instruction words to the PE instruction port, then buffers the complex data words in an internal FIFO.
- After a guaranteed idle gap, replays the buffered data to the PE data port as one contiguous burst.
- Replaces hand-driven inst_in/din_pe stimulus at array level.

Parameters:
- DATA_WIDTH, 16, width of each real/imag half; a PE data word is 2*DATA_WIDTH (real in upper half).
- INST_WIDTH, 32, PE instruction width.
- DEPTH, 16, data FIFO depth in words; power of two, at most 256.
- INST_DATA_GAP, 2, idle cycles inserted between end of collection and start of burst.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_v  in  1  host word valid.
- s_data  in  32  host word (header, instruction or data).
- s_rdy  out  1  feeder can accept; a word transfers on s_v & s_rdy.
- inst_in_v  out  1  instruction valid to PE.
- inst_in  out  INST_WIDTH  instruction to PE.
- din_pe_v  out  1  data valid to PE.
- din_pe  out  2*DATA_WIDTH  complex data to PE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse: packet fully delivered.
- err  out  1  one-cycle pulse: oversized packet header.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - State goes to IDLE; FIFO pointers and counters clear.
  - All outputs 0, except s_rdy, which is 1 (IDLE).
  - Reset mid-packet aborts the packet silently: no done, no err, partial FIFO contents discarded.
- Packet format:
  - Header word: [15:8]=n_inst, [7:0]=n_data, [31:16] ignored.
  - Followed by n_inst instruction words, then n_data data words.
- States: IDLE, INST, COLLECT, GAP, BURST, DROP.
- IDLE (s_rdy=1):
  - On header accept with n_data>DEPTH: err pulses next cycle, go to DROP.
  - Otherwise go to INST if n_inst>0, else COLLECT if n_data>0, else done pulses next cycle and stay IDLE.
- INST (s_rdy=1):
  - Each accepted word is registered to inst_in with inst_in_v=1 on the following cycle (1-cycle latency).
  - inst_in_v=0 in cycles with no accept; host bubbles pass through.
  - After the n_inst-th word: go to COLLECT if n_data>0, else done pulses and go to IDLE.
- COLLECT (s_rdy=1):
  - Accepted words are written to the FIFO; no PE outputs asserted.
  - After the n_data-th word, go to GAP.
- GAP (s_rdy=0):
  - Stay exactly INST_DATA_GAP cycles (counter), then go to BURST.
  - With INST_DATA_GAP=0, go to BURST directly.
- BURST (s_rdy=0):
  - din_pe_v=1 for exactly n_data consecutive cycles; din_pe = FIFO words in arrival order; no bubbles.
  - done pulses in the cycle after the last din_pe_v; return to IDLE.
- Burst timing: if the last data word is accepted at edge k, din_pe_v is first high in the cycle after edge k+INST_DATA_GAP+1.
- DROP (s_rdy=1): consume and discard n_inst+n_data words with no PE outputs, then go to IDLE. No done pulse.
- Output values:
  - inst_in and din_pe hold their last value when their valid is 0. The PE must ignore them.
  - inst_in_v and din_pe_v are never high in the same cycle.
- FIFO:
  - Internal pointers are log2(DEPTH) bits and wrap naturally.
  - n_data==DEPTH is legal (FIFO exactly full). Pointers return to equal after each burst.
- Host words presented while s_rdy=0 are not consumed; the host must hold s_v and s_data.

Test Plan:
- Nominal packet (INST_DATA_GAP=2): header 0x0000_0306, instructions 0x80010080, 0x80030281, 0x80050482 back-to-back, data 0x00040002, 0x00030001, 0x00080006, 0x00070005, 0x000C000A, 0x000B0009.
  - inst_in_v high for 3 consecutive cycles with those values.
  - din_pe_v high for 6 consecutive cycles, in order, starting 3 cycles after the last data accept.
  - done pulses once.
- Host bubbles: same packet with s_v low every other cycle.
  - inst_in_v has matching gaps.
  - The data burst is still 6 contiguous cycles.
- Boundaries:
  - Header 0x0000_0000: done pulses next cycle, no PE valids.
  - Header 0x0000_0200 with 0xB1010000, 0xD2030200: 2 instructions, then done, no din_pe_v.
  - Header 0x0000_0010 (16 words, DEPTH=16): full burst of 16 in order.
- Wrap: two consecutive 10-word packets. The second burst is in correct order across the pointer wrap.
- Oversize: header 0x0000_0111 (n_data=17).
  - err pulses once; 18 words are consumed.
  - No inst_in_v, din_pe_v or done.
  - A following nominal packet is delivered correctly.
- Reset mid-burst: assert rst during cycle 3 of a 6-word burst.
  - All valids drop next cycle; s_rdy=1; no done.
  - The next packet is delivered cleanly.
